t06_tick_period_meter: RTL and testbench
========================================

Name: t06_tick_period_meter

Overview:
Measures the spacing between rising edges of a tick strobe. The tick strobe is the kind produced by the team's clock-enable and strobe generators. The block reports the period in enabled clock cycles through a valid/ack result interface, and flags a timeout when no closing edge arrives. It sits beside the strobe generators as their checking and calibration partner, and lets firmware or an FSM confirm the programmed divider rate.

Parameters:
- W, 16, width of the cycle counter and of period_o.

Ports:
- clk  input  1  system clock; the only clock in the block.
- nrst  input  1  asynchronous active-low reset; clears all state.
- enable  input  1  global advance; when 0 the whole block freezes.
- tick_i  input  1  strobe under measurement; one pulse or level-high per event.
- start_i  input  1  begins a measurement; honoured in IDLE only.
- cont_i  input  1  when 1, re-arm automatically after each ack.
- ack_i  input  1  consumes the current result; honoured in DONE only.
- period_o  output  W  measured period in enabled cycles.
- valid_o  output  1  result available; held until acked.
- timeout_o  output  1  result is saturated because no closing edge arrived.
- busy_o  output  1  high when state is not IDLE; combinational from the state.

Behaviour:
- Reset: state=IDLE, cnt=0, tick_q=0, period_o=0, valid_o=0, timeout_o=0, busy_o=0.
- Enable gating: all registers, including tick_q, update only when enable=1. With enable=0, start_i, ack_i and tick_i are ignored and every output holds its value.
- Edge detect: rise = tick_i & ~tick_q.
  - A tick held high (stalled generator) counts as a single edge.
  - tick_i already high on the first enabled cycle after reset counts as an edge, since tick_q resets to 0.
- IDLE:
  - start_i=1 -> ARM.
  - Edges are ignored, but tick_q keeps tracking tick_i.
- ARM:
  - On rise: cnt<=1, go to MEASURE.
  - Otherwise stay in ARM.
- MEASURE:
  - rise: period_o<=cnt, timeout_o<=0, valid_o<=1, go to DONE.
  - No rise and cnt==all-ones: period_o<=all-ones, timeout_o<=1, valid_o<=1, go to DONE.
  - Otherwise: cnt<=cnt+1.
  - Width rule: cnt never wraps; the maximum reportable period is 2^W-1.
- DONE:
  - Edges are ignored.
  - On ack_i: valid_o<=0, then go to ARM if cont_i=1, else to IDLE.
  - period_o and timeout_o hold their values until the next result.
- Period definition: with closing and opening rising edges P enabled cycles apart, period_o=P.
  - Example: a generator with max_i=N and enable held high gives P=N+1.
- Latency: valid_o rises on the clock edge that samples the closing rise. It is visible one cycle after tick_i rises.
- Ignored or priority cases:
  - start_i outside IDLE is ignored.
  - ack_i outside DONE is ignored.
  - If rise and saturation occur in the same cycle, the rise wins and timeout_o=0.
- Reset mid-operation: returns immediately to the reset values. Any partial measurement is discarded.

Decomposition:
- Shared package t06_pkg:
  - state enum {IDLE, ARM, MEASURE, DONE}, encoded as 2 bits.
  - Constant T06_PERIOD_W=16.
- One sub-module, t06_edge_detect:
  - Ports: clk, nrst, enable, d, rise.
  - Contains the enable-gated registered rising-edge detector.
- The counter and FSM stay in the top module.

Test Plan:
- Basic period: tick pulses every 10 cycles, enable=1, start_i pulse, cont_i=0 -> period_o=10, valid_o=1, timeout_o=0. After ack_i: valid_o=0, busy_o=0.
- Enable gating: ticks 10 clk apart, with enable=0 for 3 cycles inside the interval -> period_o=7. Outputs hold during the low-enable cycles.
- Timeout: one edge after start, then tick_i=0 for 70000 cycles -> period_o=16'hFFFF, timeout_o=1, valid_o=1 after exactly 65535 enabled MEASURE cycles.
- Stalled level: tick_i high for 20 cycles, low for 5, then high again -> one edge per high run, period_o=25.
- Continuous mode: cont_i=1, spacing 5 then 8, ack each result -> results 5 then 8. Edges arriving during DONE are not counted.
- Reset mid-measure: nrst low while in MEASURE with cnt=40 -> all outputs 0, IDLE. start_i asserted while in MEASURE/DONE has no effect.

Source files
------------

// File: rtl/t06_pkg.sv
// t06_pkg: shared state encoding and default counter width for the tick period meter.
package t06_pkg;
    localparam int T06_PERIOD_W = 16;
    typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_e;
endpackage

// File: rtl/t06_edge_detect.sv
// t06_edge_detect: enable-gated registered rising-edge detector; a held-high input yields one rise.
module t06_edge_detect
    import t06_pkg::*;
(
    input  logic clk,
    input  logic nrst,
    input  logic enable,
    input  logic d,
    output logic rise
);
    logic tick_q, tick_d;
    always_comb tick_d = enable ? d : tick_q;
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) tick_q <= 1'b0;
        else       tick_q <= tick_d;
    end
    assign rise = d & ~tick_q;
endmodule

// File: rtl/t06_tick_period_meter.sv
// t06_tick_period_meter: measures enabled-cycle spacing between tick rising edges,
// reporting through a valid/ack interface with saturation timeout.
module t06_tick_period_meter
    import t06_pkg::*;
#(
    parameter int W = T06_PERIOD_W
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         enable,
    input  logic         tick_i,
    input  logic         start_i,
    input  logic         cont_i,
    input  logic         ack_i,
    output logic [W-1:0] period_o,
    output logic         valid_o,
    output logic         timeout_o,
    output logic         busy_o
);
    state_e         state_q, state_d;
    logic [W-1:0]   cnt_q, cnt_d, period_q, period_d;
    logic           valid_q, valid_d, timeout_q, timeout_d;
    logic           rise;

    t06_edge_detect u_edge (
        .clk    (clk),
        .nrst   (nrst),
        .enable (enable),
        .d      (tick_i),
        .rise   (rise)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        valid_d   = valid_q;
        timeout_d = timeout_q;
        if (enable) begin
            case (state_q)
                IDLE: state_d = start_i ? ARM : IDLE;
                ARM: begin
                    if (rise) begin
                        cnt_d   = W'(1);
                        state_d = MEASURE;
                    end
                end
                MEASURE: begin
                    // saturated cnt is all-ones, so cnt_q is the report either way; rise beats timeout
                    if (rise || &cnt_q) begin
                        period_d  = cnt_q;
                        timeout_d = ~rise;
                        valid_d   = 1'b1;
                        state_d   = DONE;
                    end else begin
                        cnt_d = cnt_q + W'(1);
                    end
                end
                DONE: begin
                    if (ack_i) begin
                        valid_d = 1'b0;
                        state_d = cont_i ? ARM : IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign period_o  = period_q;
    assign valid_o   = valid_q;
    assign timeout_o = timeout_q;
    assign busy_o    = state_q != IDLE;
endmodule

// File: tb/tb_t06_tick_period_meter.sv
// tb_t06_tick_period_meter: scoreboard bench; expected results come from enabled-cycle
// spacing of the edges the stimulus places, checked by an independent monitor.
module tb_t06_tick_period_meter;
    import t06_pkg::*;
    localparam int W = T06_PERIOD_W;

    logic clk = 1'b0, nrst = 1'b1, enable = 1'b0, tick_i = 1'b0;
    logic start_i = 1'b0, cont_i = 1'b0, ack_i = 1'b0;
    logic [W-1:0] period_o;
    logic valid_o, timeout_o, busy_o;
    int errors = 0, checks = 0;
    logic [W:0] exp_q[$];

    t06_tick_period_meter #(.W(W)) dut (
        .clk(clk), .nrst(nrst), .enable(enable), .tick_i(tick_i),
        .start_i(start_i), .cont_i(cont_i), .ack_i(ack_i),
        .period_o(period_o), .valid_o(valid_o), .timeout_o(timeout_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic en, input logic tk);
        enable = en;
        tick_i = tk;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) cyc(1'b0, 1'($urandom_range(0, 1)));
            cyc(1'b1, 1'b0);
        end
    endtask

    task automatic start();
        start_i = 1'b1;
        cyc(1'b1, 1'b0);
        start_i = 1'b0;
        chk("start_busy", 32'(busy_o), 1);
    endtask

    // opening high run of hi enabled cycles, closing edge p enabled cycles after opening
    task automatic measure(input int p, input int hi, input bit gaps);
        exp_q.push_back({1'b0, W'(p)});
        for (int i = 0; i < hi; i++) cyc(1'b1, 1'b1);
        idle(p - hi, gaps);
        cyc(1'b1, 1'b1);
        chk("latency_valid", 32'(valid_o), 1);
    endtask

    task automatic ack(input bit c);
        cont_i = c;
        ack_i  = 1'b1;
        cyc(1'b1, 1'b0);
        ack_i  = 1'b0;
        chk("ack_valid", 32'(valid_o), 0);
        chk("ack_busy", 32'(busy_o), 32'(c));
    endtask

    initial begin
        logic vp;
        logic [W:0] e;
        vp = 1'b0;
        forever begin
            @(negedge clk);
            if (valid_o === 1'b1 && !vp) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got period %0d with no expected entry", period_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("period", 32'(period_o), 32'(e[W-1:0]));
                    chk("timeout", 32'(timeout_o), 32'(e[W]));
                end
            end
            vp = valid_o === 1'b1;
        end
    end

    initial begin
        bit c;
        int p;
        #2 nrst = 1'b0;
        tick_i = 1'b1;
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        chk("rst_period", 32'(period_o), 0);
        chk("rst_valid", 32'(valid_o), 0);
        chk("rst_timeout", 32'(timeout_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        nrst = 1'b1;
        cyc(1'b1, 1'b0);
        chk("idle_ignores_tick", 32'(busy_o), 0);

        start();
        measure(10, 1, 1'b0);
        ack(1'b0);

        start();
        exp_q.push_back({1'b0, W'(7)});
        cyc(1'b1, 1'b1);
        repeat (2) cyc(1'b1, 1'b0);
        repeat (3) begin
            cyc(1'b0, 1'b0);
            chk("gate_hold_busy", 32'(busy_o), 1);
            chk("gate_hold_period", 32'(period_o), 10);
        end
        repeat (4) cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        chk("gate_valid", 32'(valid_o), 1);
        ack_i = 1'b1;
        cyc(1'b0, 1'b1);
        ack_i = 1'b0;
        chk("gate_done_hold_valid", 32'(valid_o), 1);
        chk("gate_done_hold_period", 32'(period_o), 7);
        ack(1'b0);

        start();
        measure(25, 20, 1'b0);
        ack(1'b0);

        start();
        measure(5, 1, 1'b0);
        cyc(1'b1, 1'b1);
        start_i = 1'b1;
        cyc(1'b1, 1'b0);
        start_i = 1'b0;
        chk("done_start_ignored", 32'(valid_o), 1);
        ack(1'b1);
        measure(8, 1, 1'b0);
        ack(1'b1);
        ack_i = 1'b1;
        cyc(1'b1, 1'b0);
        ack_i = 1'b0;
        chk("arm_ack_ignored", 32'(busy_o), 1);
        measure(6, 2, 1'b0);
        ack(1'b0);

        c = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (!c) start();
            p = $urandom_range(2, 60);
            measure(p, $urandom_range(1, p - 1), 1'b1);
            c = 1'($urandom_range(0, 1));
            ack(c);
        end
        if (c) ack(1'b0);
        if (busy_o) begin
            ack_i = 1'b1;
            cyc(1'b1, 1'b0);
            ack_i = 1'b0;
        end

        start();
        cyc(1'b1, 1'b1);
        start_i = 1'b1;
        idle(39, 1'b0);
        start_i = 1'b0;
        chk("measure_start_ignored", 32'(valid_o), 0);
        nrst = 1'b0;
        #1;
        chk("midrst_period", 32'(period_o), 0);
        chk("midrst_valid", 32'(valid_o), 0);
        chk("midrst_timeout", 32'(timeout_o), 0);
        chk("midrst_busy", 32'(busy_o), 0);
        @(posedge clk);
        #1 nrst = 1'b1;
        start();
        measure(3, 1, 1'b0);
        ack(1'b0);

        start();
        exp_q.push_back({1'b1, {W{1'b1}}});
        cyc(1'b1, 1'b1);
        repeat (65534) cyc(1'b1, 1'b0);
        chk("timeout_not_yet", 32'(valid_o), 0);
        cyc(1'b1, 1'b0);
        chk("timeout_valid", 32'(valid_o), 1);
        chk("timeout_flag", 32'(timeout_o), 1);
        ack(1'b0);

        repeat (3) cyc(1'b1, 1'b0);
        chk("pending_results", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
